sap_universal_register: RTL and testbench
=========================================

Name: sap_universal_register

Overview:
- Parametrised, multi-mode successor to the team's quad 4-bit bus register.
- Keeps the dual active-low load enables (g1/g2) and dual active-low output enables (m/n) with AND-gated bus output.
- Adds WIDTH generalisation, shift-left/shift-right with serial inputs, up/down counting, terminal-count and registered wrap flags.
- Used for SAP register slices: A/B registers, program counter, output shift register.

Parameters:
WIDTH, 4, register/bus width in bits (≥2)
RESET_VALUE, 0, value loaded into q on clr (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
clr  input  1  synchronous active-high reset
g1  input  1  load enable, active low
g2  input  1  load enable, active low; load = ~g1 & ~g2
m  input  1  output disable, active high
n  input  1  output disable, active high; bus_oe = ~m & ~n
mode  input  2  00 hold, 01 shift left, 10 shift right, 11 count
dir  input  1  count direction: 1 up, 0 down (ignored outside mode 11)
ser_l  input  1  serial in for shift left (enters bit 0)
ser_r  input  1  serial in for shift right (enters bit WIDTH-1)
data  input  WIDTH  parallel load data
q  output  WIDTH  register contents, always visible
bus_q  output  WIDTH  q when bus_oe, else all zero
bus_oe  output  1  ~m & ~n (combinational)
tc  output  1  terminal count (combinational)
carry  output  1  registered wrap flag

Behaviour:
- Clock and reset: single clock; all state updates on rising clk. clr is synchronous, active-high, and the highest priority.
- On clr edge: q <= RESET_VALUE, carry <= 0. No async path: clr asserted between edges changes nothing until the next edge.
- Next-state priority per edge: clr > load > mode operation.
- load (g1=0 and g2=0): q <= data, carry <= 0. mode is ignored.
- mode 00 (hold): q unchanged, carry <= 0.
- mode 01 (shift left): q <= {q[WIDTH-2:0], ser_l}; carry <= q[WIDTH-1] (bit shifted out).
- mode 10 (shift right): q <= {ser_r, q[WIDTH-1:1]}; carry <= q[0] (bit shifted out).
- mode 11, dir=1 (count up): q <= q+1 mod 2^WIDTH; carry <= 1 iff q was all ones (wrap to 0).
- mode 11, dir=0 (count down): q <= q-1 mod 2^WIDTH; carry <= 1 iff q was 0 (wrap to all ones).
- carry: holds the event of the most recent edge only; it is a one-cycle pulse unless the wrap or shift-out repeats.
- tc (combinational): (mode==11) & ((dir & q==all ones) | (~dir & q==0)); 0 in any other mode. tc does not depend on load or clr.
- bus_q / bus_oe: purely combinational from current q, m and n; zero cycle latency. Output gating never affects internal state.
- Latency: q reflects a load, shift or count one edge after the control is sampled.
- Reset values: q=RESET_VALUE, carry=0. bus_q = RESET_VALUE if bus_oe else 0. tc per formula.
- Inputs are sampled only at edges; changes to mode, dir or data between edges have no effect on state.
- The design has no X-propagation dependence: all registers are defined after the first clr edge.

Test Plan:
- WIDTH=4. clr=1 for 1 edge with RESET_VALUE=0, then g1=g2=0 data=4'hA -> q=4'hA, carry=0. Set m=0 n=0 -> bus_q=4'hA, bus_oe=1. Set m=1 -> bus_q=0, q still 4'hA.
- Load 4'hE, mode=11 dir=1, 2 edges -> q=F (tc=1, carry=0), then q=0 with carry=1 for one cycle. Next edge -> q=1, carry=0.
- Load 0, mode=11 dir=0 -> tc=1 before the edge; after the edge q=F, carry=1.
- Load 4'b1001, mode=01 ser_l=0 -> q=0010, carry=1. mode=10 ser_r=1 from q=0010 -> q=1001, carry=0.
- Priority: g1=g2=0 with mode=11 data=5 -> q=5 (no count). g1=0 g2=1 -> load inhibited, count proceeds. clr=1 with load and count active -> q=RESET_VALUE, carry=0.
- Mid-operation reset: counting up at q=7, assert clr for one edge -> q=RESET_VALUE. Deassert -> counting resumes from RESET_VALUE+1. Toggling clr between edges without an edge -> no change.

Source files
------------

// File: rtl/sap_universal_register.sv
// Multi-mode SAP register slice: parallel load, shift left/right, up/down count,
// with AND-gated bus output, combinational terminal count and registered wrap flag.
module sap_universal_register #(
  parameter int unsigned     WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             g1,
  input  logic             g2,
  input  logic             m,
  input  logic             n,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             ser_l,
  input  logic             ser_r,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] bus_q,
  output logic             bus_oe,
  output logic             tc,
  output logic             carry
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHL   = 2'b01;
  localparam logic [1:0] MODE_SHR   = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  logic             load;
  logic             q_is_max;
  logic             q_is_zero;
  logic [WIDTH-1:0] q_next;
  logic             carry_next;

  assign load      = ~g1 & ~g2;
  assign q_is_max  = (q == ALL_ONES);
  assign q_is_zero = (q == ALL_ZERO);

  // Next-state selection: load overrides any mode operation; clr is applied in the register.
  always_comb begin
    q_next     = q;
    carry_next = 1'b0;
    if (load) begin
      q_next = data;
    end else begin
      case (mode)
        MODE_HOLD: begin
          q_next = q;
        end
        MODE_SHL: begin
          q_next     = {q[WIDTH-2:0], ser_l};
          carry_next = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_next     = {ser_r, q[WIDTH-1:1]};
          carry_next = q[0];
        end
        MODE_COUNT: begin
          if (dir) begin
            q_next     = q + WIDTH'(1);
            carry_next = q_is_max;
          end else begin
            q_next     = q - WIDTH'(1);
            carry_next = q_is_zero;
          end
        end
        default: begin
          q_next = q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q     <= RESET_VALUE;
      carry <= 1'b0;
    end else begin
      q     <= q_next;
      carry <= carry_next;
    end
  end

  // Bus gating and terminal count are zero-latency views of the current state.
  assign bus_oe = ~m & ~n;
  assign bus_q  = bus_oe ? q : ALL_ZERO;
  assign tc     = (mode == MODE_COUNT) & ((dir & q_is_max) | (~dir & q_is_zero));

endmodule

// File: tb/tb_sap_universal_register.sv
// Directed bench for sap_universal_register (WIDTH=4): expected register state is
// queued as each edge is stimulated and checked once the edge has occurred.
module tb_sap_universal_register;

  logic       clk = 1'b0;
  logic       clr, g1, g2, m, n, dir, ser_l, ser_r;
  logic [1:0] mode;
  logic [3:0] data;
  logic [3:0] q, bus_q;
  logic       bus_oe, tc, carry;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic       carry;
  } exp_t;

  exp_t sb[$];

  sap_universal_register #(.WIDTH(4), .RESET_VALUE(4'h0)) dut (
    .clk(clk), .clr(clr), .g1(g1), .g2(g2), .m(m), .n(n),
    .mode(mode), .dir(dir), .ser_l(ser_l), .ser_r(ser_r), .data(data),
    .q(q), .bus_q(bus_q), .bus_oe(bus_oe), .tc(tc), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue expectation, take one rising edge, then compare away from the edge.
  task automatic edge_chk(input string tag, input logic [3:0] eq, input logic ec);
    exp_t e;
    e.tag = tag; e.q = eq; e.carry = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".q"}, q, e.q);
    check({e.tag, ".carry"}, {3'b0, carry}, {3'b0, e.carry});
  endtask

  initial begin
    clr = 1'b1; g1 = 1'b1; g2 = 1'b1; m = 1'b1; n = 1'b1;
    mode = 2'b00; dir = 1'b0; ser_l = 1'b0; ser_r = 1'b0; data = 4'h0;

    // reset
    edge_chk("reset", 4'h0, 1'b0);
    check("reset.bus_oe", {3'b0, bus_oe}, 4'h0);
    check("reset.bus_q", bus_q, 4'h0);
    check("reset.tc", {3'b0, tc}, 4'h0);

    // parallel load and bus gating
    clr = 1'b0; g1 = 1'b0; g2 = 1'b0; data = 4'hA;
    edge_chk("load_a", 4'hA, 1'b0);
    m = 1'b0; n = 1'b0; #1;
    check("bus_on.bus_q", bus_q, 4'hA);
    check("bus_on.bus_oe", {3'b0, bus_oe}, 4'h1);
    m = 1'b1; #1;
    check("bus_off.bus_q", bus_q, 4'h0);
    check("bus_off.bus_oe", {3'b0, bus_oe}, 4'h0);
    check("bus_off.q", q, 4'hA);
    n = 1'b1; m = 1'b0; #1;
    check("bus_off_n.bus_q", bus_q, 4'h0);
    m = 1'b0; n = 1'b0;

    // count up through wrap
    data = 4'hE;
    edge_chk("load_e", 4'hE, 1'b0);
    g1 = 1'b1; g2 = 1'b1; mode = 2'b11; dir = 1'b1; #1;
    check("up_e.tc", {3'b0, tc}, 4'h0);
    edge_chk("up_f", 4'hF, 1'b0);
    check("up_f.tc", {3'b0, tc}, 4'h1);
    edge_chk("up_wrap", 4'h0, 1'b1);
    check("up_wrap.tc", {3'b0, tc}, 4'h0);
    check("up_wrap.bus_q", bus_q, 4'h0);
    edge_chk("up_1", 4'h1, 1'b0);

    // count down through wrap (load wins over count)
    g1 = 1'b0; g2 = 1'b0; data = 4'h0; dir = 1'b0;
    edge_chk("load_0", 4'h0, 1'b0);
    check("load_0.tc", {3'b0, tc}, 4'h1);
    g1 = 1'b1; g2 = 1'b1; #1;
    check("dn_0.tc", {3'b0, tc}, 4'h1);
    edge_chk("dn_wrap", 4'hF, 1'b1);
    check("dn_f.tc", {3'b0, tc}, 4'h0);
    edge_chk("dn_e", 4'hE, 1'b0);
    mode = 2'b00; #1;
    check("hold.tc", {3'b0, tc}, 4'h0);
    edge_chk("hold", 4'hE, 1'b0);

    // shifts
    g1 = 1'b0; g2 = 1'b0; data = 4'b1001;
    edge_chk("load_9", 4'h9, 1'b0);
    g1 = 1'b1; g2 = 1'b1; mode = 2'b01; ser_l = 1'b0;
    edge_chk("shl", 4'b0010, 1'b1);
    mode = 2'b10; ser_r = 1'b1;
    edge_chk("shr", 4'b1001, 1'b0);
    edge_chk("shr_out1", 4'b1100, 1'b1);
    mode = 2'b01; ser_l = 1'b1;
    edge_chk("shl_in1", 4'b1001, 1'b1);

    // priority: load over count, g2 inhibits, clr over everything
    mode = 2'b11; dir = 1'b1; g1 = 1'b0; g2 = 1'b0; data = 4'h5;
    edge_chk("prio_load", 4'h5, 1'b0);
    g2 = 1'b1;
    edge_chk("prio_inhibit", 4'h6, 1'b0);
    g2 = 1'b0; data = 4'hF; clr = 1'b1;
    edge_chk("prio_clr", 4'h0, 1'b0);

    // mid-operation reset and clr glitch between edges
    clr = 1'b0; data = 4'h7;
    edge_chk("load_7", 4'h7, 1'b0);
    g1 = 1'b1; g2 = 1'b1; clr = 1'b1;
    edge_chk("mid_clr", 4'h0, 1'b0);
    clr = 1'b0;
    edge_chk("resume", 4'h1, 1'b0);
    clr = 1'b1; #2;
    clr = 1'b0; #1;
    check("glitch.q", q, 4'h1);
    edge_chk("after_glitch", 4'h2, 1'b0);

    check("sb_empty", 4'(sb.size()), 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
